// File: rtl/dec_stage.sv
// Decode stage: instruction register, 32x32 register file with write-back,
// and immediate extension. Reads are combinational from the current IR.
// Optional feature: define DEC_BYPASS_EN to forward same-cycle write data to
// a read port whose index matches the write index.
module dec_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [31:0]       Instr,
   input  logic              IR_LdEn,
   input  logic              RF_WrEn,
   input  logic              RF_WrData_sel,
   input  logic              RF_B_sel,
   input  logic [1:0]        ImmExt_sel,
   input  logic [DATA_W-1:0] ALU_out,
   input  logic [DATA_W-1:0] MEM_out,
   output logic [31:0]       IR_out,
   output logic [DATA_W-1:0] RF_A,
   output logic [DATA_W-1:0] RF_B,
   output logic [DATA_W-1:0] Immed
);

   localparam int NumRegs = 2 ** ADDR_W;

   logic [31:0]       ir_q;
   logic [DATA_W-1:0] regs_q [NumRegs];

   logic [ADDR_W-1:0] rs_idx, rd_idx, rt_idx, b_idx;
   logic [15:0]       imm;
   logic [DATA_W-1:0] wr_data;
   logic              wr_hit;

   assign rs_idx  = ir_q[21 +: ADDR_W];
   assign rd_idx  = ir_q[16 +: ADDR_W];
   assign rt_idx  = ir_q[11 +: ADDR_W];
   assign b_idx   = RF_B_sel ? rd_idx : rt_idx;
   assign imm     = ir_q[15:0];
   assign wr_data = RF_WrData_sel ? MEM_out : ALU_out;
   // Register 0 is hardwired to zero, so writes to it never take effect.
   assign wr_hit  = RF_WrEn && (rd_idx != '0);
   assign IR_out  = ir_q;

   // IR load and register write-back; write index comes from the outgoing IR.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         ir_q <= '0;
         for (int i = 0; i < NumRegs; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         if (wr_hit) begin
            regs_q[rd_idx] <= wr_data;
         end
         if (IR_LdEn) begin
            ir_q <= Instr;
         end
      end
   end

   // Combinational read ports, with optional same-cycle write forwarding.
   always_comb begin
      RF_A = (rs_idx == '0) ? '0 : regs_q[rs_idx];
      RF_B = (b_idx == '0) ? '0 : regs_q[b_idx];
`ifdef DEC_BYPASS_EN
      if (wr_hit && (rs_idx == rd_idx)) begin
         RF_A = wr_data;
      end
      if (wr_hit && (b_idx == rd_idx)) begin
         RF_B = wr_data;
      end
`endif
   end

   // Immediate extension of IR[15:0].
   always_comb begin
      Immed = '0;
      unique case (ImmExt_sel)
         2'b00: Immed = {{(DATA_W-16){1'b0}}, imm};
         2'b01: Immed = {{(DATA_W-16){imm[15]}}, imm};
         // Branch offset: sign-extend then scale by 4, upper bits drop off.
         2'b10: Immed = {{(DATA_W-16){imm[15]}}, imm} << 2;
         2'b11: Immed = {{(DATA_W-16){1'b0}}, imm} << 16;
         default: Immed = '0;
      endcase
   end

endmodule

// File: tb/tb_dec_stage.sv
// Self-checking bench for dec_stage: spec-level model checked every cycle,
// plus directed vectors with literal expectations.
module tb_dec_stage;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] Instr;
   logic        IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel;
   logic [1:0]  ImmExt_sel;
   logic [31:0] ALU_out, MEM_out;
   logic [31:0] IR_out, RF_A, RF_B, Immed;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Model state
   logic [31:0] ir_m;
   logic [31:0] regs_m [32];

   dec_stage #(.DATA_W(32), .ADDR_W(5)) dut (
      .Clk(Clk), .Reset(Reset), .Instr(Instr), .IR_LdEn(IR_LdEn),
      .RF_WrEn(RF_WrEn), .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel),
      .ImmExt_sel(ImmExt_sel), .ALU_out(ALU_out), .MEM_out(MEM_out),
      .IR_out(IR_out), .RF_A(RF_A), .RF_B(RF_B), .Immed(Immed)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: state update at each rising edge from the behavioural rules.
   always @(posedge Clk) begin
      if (Reset) begin
         ir_m = 32'h0;
         for (int i = 0; i < 32; i++) regs_m[i] = 32'h0;
      end else begin
         if (RF_WrEn && ir_m[20:16] != 5'd0)
            regs_m[ir_m[20:16]] = RF_WrData_sel ? MEM_out : ALU_out;
         if (IR_LdEn) ir_m = Instr;
      end
   end

   function automatic logic [31:0] model_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'h0;
`ifdef DEC_BYPASS_EN
      if (RF_WrEn && ir_m[20:16] != 5'd0 && idx == ir_m[20:16])
         return RF_WrData_sel ? MEM_out : ALU_out;
`endif
      return regs_m[idx];
   endfunction

   function automatic logic [31:0] model_imm(input logic [15:0] imm, input logic [1:0] sel);
      logic signed [31:0] s;
      s = 32'($signed(imm));
      case (sel)
         2'd0: return {16'h0, imm};
         2'd1: return s;
         2'd2: return s * 4;
         default: return {16'h0, imm} * 32'd65536;
      endcase
   endfunction

   // Compare process: every cycle once the first reset has taken effect.
   always @(negedge Clk) begin
      if (chk_en) begin
         chk("IR_out", IR_out, ir_m);
         chk("RF_A", RF_A, model_read(ir_m[25:21]));
         chk("RF_B", RF_B, model_read(RF_B_sel ? ir_m[20:16] : ir_m[15:11]));
         chk("Immed", Immed, model_imm(ir_m[15:0], ImmExt_sel));
      end
   end

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic settle;
      @(negedge Clk);
      #1;
   endtask

   task automatic idle;
      IR_LdEn = 1'b0;
      RF_WrEn = 1'b0;
   endtask

   logic [31:0] exp5;

   initial begin
      Reset = 1'b1; Instr = 32'h0; IR_LdEn = 1'b0; RF_WrEn = 1'b0;
      RF_WrData_sel = 1'b0; RF_B_sel = 1'b0; ImmExt_sel = 2'd0;
      ALU_out = 32'h0; MEM_out = 32'h0;
      tick;
      Reset = 1'b0;
      chk_en = 1'b1;

      // 1: random writes, then a single reset edge clears everything
      for (int i = 0; i < 40; i++) begin
         Instr = $urandom; IR_LdEn = 1'b1; RF_WrEn = 1'b1;
         RF_WrData_sel = 1'($urandom); ALU_out = $urandom; MEM_out = $urandom;
         tick;
      end
      Reset = 1'b1; idle();
      tick;
      Reset = 1'b0;
      settle;
      chk("T1 IR_out", IR_out, 32'h0);
      chk("T1 RF_A", RF_A, 32'h0);
      chk("T1 RF_B", RF_B, 32'h0);
      chk("T1 Immed", Immed, 32'h0);
      for (int r = 0; r < 32; r++) begin
         Instr = (32'(r) << 21) | (32'(r) << 11); IR_LdEn = 1'b1; RF_B_sel = 1'b0;
         tick;
         IR_LdEn = 1'b0;
         settle;
         chk("T1 reg via A", RF_A, 32'h0);
         chk("T1 reg via B", RF_B, 32'h0);
      end

      // 2: IR load latency and fields
      Instr = 32'h00A5_8000; IR_LdEn = 1'b1;
      tick;
      IR_LdEn = 1'b0;
      settle;
      chk("T2 IR_out", IR_out, 32'h00A58000);
      chk("T2 rs", {27'h0, IR_out[25:21]}, 32'd5);
      chk("T2 rd", {27'h0, IR_out[20:16]}, 32'd5);
      chk("T2 rt", {27'h0, IR_out[15:11]}, 32'd16);

      // 3: write reg3 via ALU while loading an IR that reads rs=3
      Instr = 32'h0003_0000; IR_LdEn = 1'b1;
      tick;
      Instr = 32'h0060_0000; RF_WrEn = 1'b1; RF_WrData_sel = 1'b0; ALU_out = 32'hDEADBEEF;
      tick;
      idle();
      settle;
      chk("T3 reg3", RF_A, 32'hDEADBEEF);
      // IR rd=0 now: write is discarded; load rs=0 at the same edge
      Instr = 32'h0; IR_LdEn = 1'b1; RF_WrEn = 1'b1; ALU_out = 32'h5555_5555;
      tick;
      idle();
      settle;
      chk("T3 reg0", RF_A, 32'h0);

      // 4: immediate modes on imm=0x8004
      Instr = 32'h0000_8004; IR_LdEn = 1'b1;
      tick;
      idle();
      ImmExt_sel = 2'd0; settle; chk("T4 zext", Immed, 32'h0000_8004);
      ImmExt_sel = 2'd1; settle; chk("T4 sext", Immed, 32'hFFFF_8004);
      ImmExt_sel = 2'd2; settle; chk("T4 branch", Immed, 32'hFFFE_0010);
      ImmExt_sel = 2'd3; settle; chk("T4 upper", Immed, 32'h8004_0000);

      // 5: read-during-write on reg7 from memory data
      Instr = 32'h00E7_0000; IR_LdEn = 1'b1;
      tick;
      IR_LdEn = 1'b0; RF_WrEn = 1'b1; RF_WrData_sel = 1'b1;
      MEM_out = 32'h1234; ALU_out = 32'h0BAD;
`ifdef DEC_BYPASS_EN
      exp5 = 32'h1234;
`else
      exp5 = 32'h0;
`endif
      settle;
      chk("T5 same cycle", RF_A, exp5);
      tick;
      idle();
      settle;
      chk("T5 next cycle", RF_A, 32'h1234);

      // 6: reset beats load and write in the same cycle (IR rd=7 here)
      Reset = 1'b1; Instr = 32'hFFFF_FFFF; IR_LdEn = 1'b1; RF_WrEn = 1'b1;
      MEM_out = 32'h7777;
      tick;
      Reset = 1'b0; idle();
      settle;
      chk("T6 IR_out", IR_out, 32'h0);
      Instr = 32'h00E0_0000; IR_LdEn = 1'b1;
      tick;
      idle();
      settle;
      chk("T6 reg7", RF_A, 32'h0);
      // reg1=0x11, reg2=0x22, then IR rd=1 rt=2 and toggle RF_B_sel
      RF_WrData_sel = 1'b0;
      Instr = 32'h0001_0000; IR_LdEn = 1'b1;
      tick;
      Instr = 32'h0002_0000; RF_WrEn = 1'b1; ALU_out = 32'h11;
      tick;
      Instr = 32'h0001_1000; RF_WrEn = 1'b1; ALU_out = 32'h22;
      tick;
      idle();
      RF_B_sel = 1'b1; settle; chk("T6 B=rd", RF_B, 32'h11);
      RF_B_sel = 1'b0; settle; chk("T6 B=rt", RF_B, 32'h22);

      // Random traffic against the model
      for (int i = 0; i < 300; i++) begin
         Reset = ($urandom_range(0, 29) == 0);
         Instr = $urandom; IR_LdEn = 1'($urandom); RF_WrEn = 1'($urandom);
         RF_WrData_sel = 1'($urandom); RF_B_sel = 1'($urandom);
         ImmExt_sel = 2'($urandom); ALU_out = $urandom; MEM_out = $urandom;
         tick;
      end
      Reset = 1'b0; idle();
      settle;
      chk_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
